led_mode_ctrl: RTL and testbench

Board-level LED controller sitting between the raw push-button input and the single user LED in the 125 MHz blink design. Synchronises and debounces `btn_in`, and turns each debounced press into one mode advance of a five-state pattern FSM (off, solid, slow blink, fast blink, dim PWM). Drives `led_out` from a shared free-running prescaler, replacing the fixed counter-bit LED drive in `top`.

---
 rtl/led_mode_ctrl_if.sv | 22 ++
 rtl/led_mode_ctrl.sv | 116 +++++++++++
 tb/tb_led_mode_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/led_mode_ctrl_if.sv
// Button/LED signal bundle for led_mode_ctrl.
// The slave side is the controller; the master side is whatever drives the button.
interface led_mode_ctrl_if;
    logic       btn_in;
    logic       led_out;
    logic [2:0] mode_o;
    logic       btn_pulse_o;

    modport master (
        output btn_in,
        input  led_out,
        input  mode_o,
        input  btn_pulse_o
    );

    modport slave (
        input  btn_in,
        output led_out,
        output mode_o,
        output btn_pulse_o
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// LED mode controller: synchronises and debounces a push button, advances a
// five-state pattern FSM on each debounced press and drives the LED from a
// shared free-running prescaler.
module led_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1250000,
    parameter int unsigned SLOW_BIT        = 26,
    parameter int unsigned FAST_BIT        = 24,
    parameter int unsigned PWM_BITS        = 4,
    parameter int unsigned PWM_DUTY        = 2,
    parameter logic [2:0]  RESET_MODE      = 3'd2
) (
    input logic             clk125_i,
    input logic             reset,
    led_mode_ctrl_if.slave  bus
);

    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CntW = SLOW_BIT + 1;
    localparam int unsigned PwmW = PWM_BITS + 1;

    // Last count value before a disagreement run is accepted.
    localparam logic [DbW-1:0]  DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    // One extra bit so a duty of 2^PWM_BITS (always on) still compares correctly.
    localparam logic [PwmW-1:0] Duty   = PwmW'(PWM_DUTY);

    typedef enum logic [2:0] {
        ModeOff   = 3'd0,
        ModeSolid = 3'd1,
        ModeSlow  = 3'd2,
        ModeFast  = 3'd3,
        ModeDim   = 3'd4
    } mode_e;

    logic            btn_meta;
    logic            btn_s;
    logic            btn_db;
    logic            btn_db_prev;
    logic [DbW-1:0]  db_cnt;
    logic [CntW-1:0] cnt;
    mode_e           mode;

    assign bus.mode_o = mode;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk125_i) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= bus.btn_in;
            btn_s    <= btn_meta;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge clk125_i) begin
        if (reset) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DbLast) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Press detect: one-cycle strobe the cycle after the debounced level rises.
    always_ff @(posedge clk125_i) begin
        if (reset) begin
            btn_db_prev     <= 1'b0;
            bus.btn_pulse_o <= 1'b0;
        end else begin
            btn_db_prev     <= btn_db;
            bus.btn_pulse_o <= btn_db & ~btn_db_prev;
        end
    end

    // Mode FSM and prescaler; the prescaler restarts on every advance so patterns begin on.
    always_ff @(posedge clk125_i) begin
        if (reset) begin
            mode <= mode_e'(RESET_MODE);
            cnt  <= '0;
        end else if (bus.btn_pulse_o) begin
            cnt <= '0;
            case (mode)
                ModeOff:   mode <= ModeSolid;
                ModeSolid: mode <= ModeSlow;
                ModeSlow:  mode <= ModeFast;
                ModeFast:  mode <= ModeDim;
                default:   mode <= ModeOff;
            endcase
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered LED drive from the current mode and prescaler phase.
    always_ff @(posedge clk125_i) begin
        if (reset) begin
            bus.led_out <= 1'b0;
        end else begin
            case (mode)
                ModeOff:   bus.led_out <= 1'b0;
                ModeSolid: bus.led_out <= 1'b1;
                ModeSlow:  bus.led_out <= ~cnt[SLOW_BIT];
                ModeFast:  bus.led_out <= ~cnt[FAST_BIT];
                ModeDim:   bus.led_out <= ({1'b0, cnt[PWM_BITS-1:0]} < Duty);
                default:   bus.led_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with small debounce/prescaler parameters.
// Expected press strobes are queued when the button is driven and matched by a monitor.
module tb_led_mode_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  mode;
    } exp_t;

    exp_t        sb[$];
    logic        mon_en = 1'b0;
    logic        mode_pend = 1'b0;
    logic [2:0]  mode_exp = 3'd0;
    logic        exp_pulse;
    logic [2:0]  cur_mode = 3'd2;

    led_mode_ctrl_if bus ();

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .SLOW_BIT        (5),
        .FAST_BIT        (3),
        .PWM_BITS        (3),
        .PWM_DUTY        (2),
        .RESET_MODE      (3'd2)
    ) dut (
        .clk125_i (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference LED pattern for mode m at phase p cycles after the pattern starts.
    function automatic logic exp_led(input logic [2:0] m, input int p);
        case (m)
            3'd0:    return 1'b0;
            3'd1:    return 1'b1;
            3'd2:    return ((p / 32) % 2) == 0;
            3'd3:    return ((p / 8) % 2) == 0;
            3'd4:    return (p % 8) < 2;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: every cycle the strobe must match the queue head; mode follows one cycle later.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mode_pend) begin
                check("mode_after_pulse", {29'd0, bus.mode_o}, {29'd0, mode_exp});
                mode_pend = 1'b0;
            end
            exp_pulse = (sb.size() > 0) && (sb[0].cyc == cyc);
            check("btn_pulse", {31'd0, bus.btn_pulse_o}, {31'd0, exp_pulse});
            if (exp_pulse) begin
                mode_exp  = sb[0].mode;
                mode_pend = 1'b1;
                void'(sb.pop_front());
            end
        end
    end

    // Follow a press that became visible to the DUT at the current negedge.
    task automatic watch(input int hold, input int span, input logic [2:0] m);
        for (int i = 1; i <= span; i++) begin
            @(negedge clk);
            if (i >= 9) check($sformatf("led_mode%0d", m), {31'd0, bus.led_out},
                              {31'd0, exp_led(m, i - 9)});
            if (i == hold) bus.btn_in = 1'b0;
        end
    endtask

    task automatic press(input int hold, input int span);
        logic [2:0] nm;
        nm = (cur_mode == 3'd4) ? 3'd0 : cur_mode + 3'd1;
        bus.btn_in = 1'b1;
        sb.push_back('{cyc: cyc + 7, mode: nm});
        cur_mode = nm;
        watch(hold, span, nm);
    endtask

    initial begin
        bus.btn_in = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        check("reset_mode", {29'd0, bus.mode_o}, 32'd2);
        check("reset_led", {31'd0, bus.led_out}, 32'd0);
        check("reset_pulse", {31'd0, bus.btn_pulse_o}, 32'd0);
        mon_en = 1'b1;
        reset  = 1'b0;

        // Slow blink straight out of reset: 32 on, 32 off
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            check("led_after_reset", {31'd0, bus.led_out}, {31'd0, exp_led(3'd2, i - 1)});
        end

        // Clean press: 2 -> 3 (fast blink)
        press(20, 36);
        check("mode_clean", {29'd0, bus.mode_o}, {29'd0, cur_mode});

        // Bounce shorter than the debounce window is ignored
        bus.btn_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_in = 1'b0;
        @(negedge clk);
        bus.btn_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_in = 1'b0;
        repeat (15) @(negedge clk);
        check("mode_bounce", {29'd0, bus.mode_o}, {29'd0, cur_mode});

        // Five presses: 4, 0, 1, 2, 3 with pattern checks in each mode
        for (int k = 0; k < 5; k++) begin
            press(10, 30);
            check("mode_wrap", {29'd0, bus.mode_o}, {29'd0, cur_mode});
        end

        // Reset in the middle of a debounce, button held through release
        bus.btn_in = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_mode", {29'd0, bus.mode_o}, 32'd2);
        check("midreset_led", {31'd0, bus.led_out}, 32'd0);
        reset = 1'b0;
        cur_mode = 3'd3;
        sb.push_back('{cyc: cyc + 7, mode: 3'd3});
        watch(10, 30, 3'd3);
        check("mode_midreset", {29'd0, bus.mode_o}, 32'd3);

        // Long hold produces a single advance
        press(500, 520);
        check("mode_long", {29'd0, bus.mode_o}, {29'd0, cur_mode});

        repeat (10) @(negedge clk);
        mon_en = 1'b0;
        check("pulses_outstanding", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
